// File: rtl/sysref_sync_ctrl_if.sv
// Bundles the SYSREF sample, software arm/abort controls and status of sysref_sync_ctrl.
// The master side is the capture/software side; the slave side is the controller.
interface sysref_sync_ctrl_if #(
  parameter int CW = 16
);
  logic          sysref_in;
  logic          arm;
  logic          abort;
  logic          sysref_out;
  logic          sysref_edge;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] meas_period;
  logic [2:0]    state;

  modport master (
    output sysref_in, arm, abort,
    input  sysref_out, sysref_edge, busy, done, err, err_code, meas_period, state
  );

  modport slave (
    input  sysref_in, arm, abort,
    output sysref_out, sysref_edge, busy, done, err, err_code, meas_period, state
  );
endinterface

// File: rtl/sysref_sync_ctrl.sv
// SYSREF sequencing controller: after arm, verifies the PL SYSREF period, then forwards
// FWD_EDGES whole pulses to the converter sync input. Optional macro: SYSREF_TIMEOUT_EN.
module sysref_sync_ctrl #(
  parameter int PERIOD     = 64,
  parameter int TOL        = 1,
  parameter int LOCK_EDGES = 4,
  parameter int FWD_EDGES  = 8,
  parameter int MAX_RETRY  = 3,
`ifdef SYSREF_TIMEOUT_EN
  parameter int TIMEOUT    = 4096,
`endif
  parameter int CW         = 16
) (
  input  logic              pl_clk,
  input  logic              pl_rst,
  sysref_sync_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_MEASURE = 3'd2,
    S_FORWARD = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] PER_LO  = CW'((PERIOD > TOL) ? (PERIOD - TOL) : 0);
  localparam logic [CW-1:0] PER_HI  = CW'(PERIOD + TOL);
  localparam logic [7:0]    LOCK_N  = 8'(LOCK_EDGES);
  localparam logic [7:0]    RETRY_N = 8'(MAX_RETRY);
  localparam logic [7:0]    FWD_N   = 8'(FWD_EDGES);

  state_e        state_q;
  logic          sysref_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] meas_period_q;
  logic [7:0]    good_q, retry_q, fwd_q;
  logic          gate_q;
  logic          sysref_out_q, sysref_edge_q;
  logic          done_q, err_q;
  logic [1:0]    err_code_q;

  logic rise, match, busy_w, timeout_hit;

  assign rise   = bus.sysref_in & ~sysref_dly_q;
  assign match  = (cnt_q >= PER_LO) && (cnt_q <= PER_HI);
  assign busy_w = (state_q == S_ARM) || (state_q == S_MEASURE) || (state_q == S_FORWARD);

`ifdef SYSREF_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic arm_ok;
  assign arm_ok      = bus.arm & ~bus.abort & ~busy_w;
  assign timeout_hit = busy_w & ~rise & (cnt_q >= TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Period counter: restarts at 1 on every rise so cnt equals the period on the next rise.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CW'(1);
`ifdef SYSREF_TIMEOUT_EN
    end else if (arm_ok) begin
      cnt_d = '0;
`endif
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      state_q       <= S_IDLE;
      sysref_dly_q  <= 1'b0;
      cnt_q         <= '0;
      meas_period_q <= '0;
      good_q        <= '0;
      retry_q       <= '0;
      fwd_q         <= '0;
      gate_q        <= 1'b0;
      sysref_out_q  <= 1'b0;
      sysref_edge_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      sysref_dly_q  <= bus.sysref_in;
      cnt_q         <= cnt_d;
      sysref_edge_q <= 1'b0;
      // The ARM edge only starts the first period, it is not a measurement.
      if (rise && state_q != S_ARM) meas_period_q <= cnt_q;

      if (bus.abort) begin
        state_q      <= S_IDLE;
        gate_q       <= 1'b0;
        sysref_out_q <= 1'b0;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
        err_code_q   <= 2'd0;
      end else if (timeout_hit) begin
        state_q      <= S_ERROR;
        gate_q       <= 1'b0;
        sysref_out_q <= 1'b0;
        err_q        <= 1'b1;
        err_code_q   <= 2'd3;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE, S_ERROR: begin
            if (bus.arm) begin
              state_q    <= S_ARM;
              good_q     <= '0;
              retry_q    <= '0;
              fwd_q      <= '0;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= 2'd0;
            end
          end
          S_ARM: begin
            if (rise) begin
              state_q <= S_MEASURE;
              good_q  <= '0;
              retry_q <= '0;
            end
          end
          S_MEASURE: begin
            if (rise) begin
              if (match) begin
                good_q <= good_q + 8'd1;
                if (good_q + 8'd1 == LOCK_N) begin
                  state_q <= S_FORWARD;
                  fwd_q   <= '0;
                  gate_q  <= 1'b0;
                end
              end else begin
                good_q  <= '0;
                retry_q <= retry_q + 8'd1;
                if (retry_q + 8'd1 == RETRY_N) begin
                  state_q    <= S_ERROR;
                  err_q      <= 1'b1;
                  err_code_q <= 2'd1;
                end
              end
            end
          end
          S_FORWARD: begin
            if (rise && !match) begin
              state_q      <= S_ERROR;
              gate_q       <= 1'b0;
              sysref_out_q <= 1'b0;
              err_q        <= 1'b1;
              err_code_q   <= 2'd2;
            end else begin
              sysref_out_q <= gate_q & bus.sysref_in;
              if (rise && gate_q) begin
                fwd_q         <= fwd_q + 8'd1;
                sysref_edge_q <= 1'b1;
              end
              // Gate only changes while SYSREF is low, so pulses are never cut.
              if (!bus.sysref_in) begin
                if (fwd_q == FWD_N) begin
                  gate_q  <= 1'b0;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  gate_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sysref_out  = sysref_out_q;
  assign bus.sysref_edge = sysref_edge_q;
  assign bus.busy        = busy_w;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.meas_period = meas_period_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_sysref_sync_ctrl.sv
// Bench for sysref_sync_ctrl: table of SYSREF scenarios plus hand-written abort, reset
// and timeout sequences; forwarded edges are checked against a cycle-stamped scoreboard.
module tb_sysref_sync_ctrl;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sysref_sync_ctrl_if #(.CW(CW)) bus ();
  sysref_sync_ctrl #(.CW(CW)) dut (.pl_clk(clk), .pl_rst(rst), .bus(bus));

  typedef struct {
    int hi;        // SYSREF high width
    int per;       // nominal period
    int pre_bad;   // mismatched periods before the nominal ones
    int n_good;    // nominal periods
    int bad_per;   // mismatched period value
    int n_bad;     // mismatched periods after the nominal ones
    int fwd_first; // index of first edge that must be forwarded
    int fwd_cnt;   // number of forwarded edges
    bit arm_busy;  // re-pulse arm while busy
    int st;
    int code;
    int done;
    int meas;
  } vec_t;

  vec_t vecs[10];
  int   exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   edge_cnt = 0;
  int   cur = -1;
  bit   fwd_drive = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (vec %0d, cycle %0d): got %0d, want %0d", nm, cur, cyc, act, exp);
    end
  endtask

  // One clock: sysref_out must follow the intended-forwarded input one cycle late, and
  // every sysref_edge must land on the cycle recorded when its rise was driven.
  task automatic tick();
    bit e;
    e = bus.sysref_in & fwd_drive;
    @(posedge clk);
    #1;
    cyc++;
    chk("sysref_out", bus.sysref_out, e);
    if (bus.sysref_edge === 1'b1) begin
      edge_cnt++;
      if (exp_q.size() == 0) chk("unexpected_edge", 1, 0);
      else chk("edge_cycle", cyc, exp_q.pop_front());
    end
  endtask

  task automatic drive_pulse(input int hi, input int lo, input bit fwd, input bit arm_mid);
    if (fwd) exp_q.push_back(cyc + 1);
    bus.sysref_in = 1'b1;
    fwd_drive     = fwd;
    repeat (hi) tick();
    bus.sysref_in = 1'b0;
    fwd_drive     = 1'b0;
    if (arm_mid) begin
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
      chk("arm_busy_state", bus.state, 2);
      repeat (lo - 1) tick();
    end else begin
      repeat (lo) tick();
    end
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("arm_state", bus.state, 1);
    chk("arm_busy", bus.busy, 1);
    chk("arm_done", bus.done, 0);
    chk("arm_err", bus.err, 0);
    repeat (5) tick();
  endtask

  task automatic run_vec(input vec_t v);
    int pers[$];
    int e0;
    int n;
    e0 = edge_cnt;
    do_arm();
    for (int i = 0; i < v.pre_bad; i++) pers.push_back(v.bad_per);
    for (int i = 0; i < v.n_good; i++)  pers.push_back(v.per);
    for (int i = 0; i < v.n_bad; i++)   pers.push_back(v.bad_per);
    n = pers.size();
    for (int i = 0; i <= n; i++) begin
      int lo;
      lo = (i < n) ? (pers[i] - v.hi) : 10;
      drive_pulse(v.hi, lo, (i >= v.fwd_first) && (i < v.fwd_first + v.fwd_cnt),
                  v.arm_busy && (i == 2));
    end
    chk("state", bus.state, v.st);
    chk("err_code", bus.err_code, v.code);
    chk("err", bus.err, (v.code != 0) ? 1 : 0);
    chk("done", bus.done, v.done);
    chk("busy", bus.busy, 0);
    chk("meas_period", bus.meas_period, v.meas);
    chk("fwd_edges", edge_cnt - e0, v.fwd_cnt);
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Arm, lock on 64-cycle periods and stop 10 cycles into the first forwarded pulse.
  task automatic to_forward_mid();
    do_arm();
    for (int i = 0; i < 5; i++) drive_pulse(32, 32, 1'b0, 1'b0);
    exp_q.push_back(cyc + 1);
    bus.sysref_in = 1'b1;
    fwd_drive     = 1'b1;
    repeat (10) tick();
    chk("fwd_mid_out", bus.sysref_out, 1);
    fwd_drive = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          hi  per pre good bad nbad ff fc arm st code done meas
    vecs[0] = '{32, 64, 0, 12, 0,  0,  5, 8, 1'b0, 4, 0, 1, 64};
    vecs[1] = '{32, 65, 0, 12, 0,  0,  5, 8, 1'b1, 4, 0, 1, 65};
    vecs[2] = '{32, 64, 0, 0,  66, 3,  0, 0, 1'b0, 5, 1, 0, 66};
    vecs[3] = '{32, 64, 0, 7,  70, 1,  5, 3, 1'b0, 5, 2, 0, 70};
    vecs[4] = '{32, 63, 0, 12, 0,  0,  5, 8, 1'b0, 4, 0, 1, 63};
    vecs[5] = '{32, 64, 0, 0,  62, 3,  0, 0, 1'b0, 5, 1, 0, 62};
    vecs[6] = '{1,  64, 0, 12, 0,  0,  5, 8, 1'b0, 4, 0, 1, 64};
    vecs[7] = '{63, 64, 0, 12, 0,  0,  5, 8, 1'b0, 4, 0, 1, 64};
    vecs[8] = '{32, 64, 2, 12, 70, 0,  7, 8, 1'b0, 4, 0, 1, 64};
    vecs[9] = '{32, 64, 2, 2,  70, 1,  0, 0, 1'b0, 5, 1, 0, 70};

    bus.sysref_in = 1'b0;
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    repeat (3) tick();
    chk("rst_state", bus.state, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_meas", bus.meas_period, 0);
    chk("rst_edge", bus.sysref_edge, 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Abort out of ERROR clears the sticky error.
    cur = 100;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_err_state", bus.state, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_err_code", bus.err_code, 0);

    // Abort in the middle of a forwarded pulse.
    cur = 101;
    to_forward_mid();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_state", bus.state, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (5) tick();
    bus.sysref_in = 1'b0;
    repeat (10) tick();
    chk("abort_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // Abort beats a simultaneous arm.
    cur = 102;
    bus.arm   = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    chk("abort_arm_state", bus.state, 0);

    // Synchronous reset in the middle of a forwarded pulse.
    cur = 103;
    to_forward_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.sysref_in = 1'b0;
    chk("rst_mid_state", bus.state, 0);
    chk("rst_mid_meas", bus.meas_period, 0);
    chk("rst_mid_busy", bus.busy, 0);
    repeat (10) tick();
    chk("rst_mid_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // SYSREF stopped after arm.
    cur = 104;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    repeat (4095) tick();
    chk("tmo_pre_state", bus.state, 1);
    tick();
`ifdef SYSREF_TIMEOUT_EN
    chk("tmo_state", bus.state, 5);
    chk("tmo_err_code", bus.err_code, 3);
    chk("tmo_err", bus.err, 1);
    chk("tmo_busy", bus.busy, 0);
`else
    chk("tmo_state", bus.state, 1);
    chk("tmo_err_code", bus.err_code, 0);
    chk("tmo_busy", bus.busy, 1);
    repeat (200) tick();
    chk("tmo_late_state", bus.state, 1);
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("tmo_abort_state", bus.state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
